// File: rtl/insn_fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package insn_fetch_pkg;

    localparam int DEF_INSN_COUNT    = 64;
    localparam int DEF_INSN_SIZE     = 32;
    localparam int DEF_INSN_PTR_SIZE = 8;
    localparam int FETCH_CNT_SIZE    = 16;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/insn_fetch.sv
// Fetch stage: drives the instruction memory pointer, registers the returned
// word into a single output slot and hands it to decode over valid/ready.
module insn_fetch
    import insn_fetch_pkg::*;
#(
    parameter int INSN_COUNT    = DEF_INSN_COUNT,
    parameter int INSN_SIZE     = DEF_INSN_SIZE,
    parameter int INSN_PTR_SIZE = DEF_INSN_PTR_SIZE,
    parameter int CNT_SIZE      = FETCH_CNT_SIZE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [INSN_PTR_SIZE-1:0] start_ptr,
    output logic [INSN_PTR_SIZE-1:0] insn_ptr,
    input  logic [INSN_SIZE-1:0]     insn_curr,
    output logic                     fetch_valid,
    output logic [INSN_SIZE-1:0]     fetch_insn,
    output logic [INSN_PTR_SIZE-1:0] fetch_ptr,
    input  logic                     fetch_ready,
    input  logic                     redirect,
    input  logic [INSN_PTR_SIZE-1:0] redirect_ptr,
    input  logic                     halt,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_SIZE-1:0]      fetch_count,
    output logic [1:0]               state_dbg
);

    // Handshake: a transfer happens at an edge where fetch_valid & fetch_ready;
    // fetch_insn/fetch_ptr stay stable while fetch_valid & ~fetch_ready.

    localparam logic [INSN_PTR_SIZE-1:0] LAST_PTR = INSN_PTR_SIZE'(INSN_COUNT - 1);
    localparam logic [INSN_PTR_SIZE-1:0] PTR_ONE  = INSN_PTR_SIZE'(1);
    localparam logic [CNT_SIZE-1:0]      CNT_ONE  = CNT_SIZE'(1);

    fetch_state_t             state_q, state_d;
    logic [INSN_PTR_SIZE-1:0] pc_q, pc_d;
    logic                     valid_q, valid_d;
    logic [INSN_SIZE-1:0]     insn_q, insn_d;
    logic [INSN_PTR_SIZE-1:0] ptr_q, ptr_d;
    logic [CNT_SIZE-1:0]      cnt_q, cnt_d;

    logic                     handshake;
    logic                     load;
    logic [INSN_PTR_SIZE-1:0] pc_next;

    assign handshake = (state_q == FETCH_RUN) && valid_q && fetch_ready;
    assign load      = ~valid_q | fetch_ready;
    assign pc_next   = (pc_q == LAST_PTR) ? '0 : pc_q + PTR_ONE;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        insn_d  = insn_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;

        case (state_q)
            FETCH_IDLE, FETCH_DONE: begin
                if (start) begin
                    pc_d    = start_ptr;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    state_d = FETCH_RUN;
                end
            end
            FETCH_RUN: begin
                // The handshake counts even when the slot is flushed this edge.
                if (handshake && !(&cnt_q)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                if (redirect) begin
                    pc_d    = redirect_ptr;
                    valid_d = 1'b0;
                end else if (halt) begin
                    valid_d = 1'b0;
                    state_d = FETCH_DONE;
                end else if (load) begin
                    insn_d  = insn_curr;
                    ptr_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_next;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH_IDLE;
            pc_q    <= '0;
            valid_q <= 1'b0;
            insn_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            insn_q  <= insn_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign insn_ptr    = pc_q;
    assign fetch_valid = valid_q;
    assign fetch_insn  = insn_q;
    assign fetch_ptr   = ptr_q;
    assign fetch_count = cnt_q;
    assign busy        = (state_q == FETCH_RUN);
    assign done        = (state_q == FETCH_DONE);
    assign state_dbg   = state_q;

endmodule

// File: doc/insn_fetch.md
Name: insn_fetch

Overview:
- Fetch stage directly downstream of the core instruction memory.
- Drives the memory read pointer (insn_ptr) and captures the combinational read word (insn_curr) into a registered output slot.
- Hands instructions to decode over a valid/ready handshake.
- Supports start from a given pointer, branch redirect from execute, and halt from decode.

Parameters:
- INSN_COUNT, `INSN_COUNT, number of instruction words in memory; PC wrap point.
- INSN_SIZE, `INSN_SIZE, instruction width in bits.
- INSN_PTR_SIZE, `INSN_PTR_SIZE, pointer/PC width in bits.
- CNT_SIZE, 16, width of the fetched-instruction counter.

Ports:
- clk  input  1  core clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (reset==0 clears all state immediately).
- start  input  1  begin execution at start_ptr; sampled only in IDLE or DONE.
- start_ptr  input  INSN_PTR_SIZE  first instruction address.
- insn_ptr  output  INSN_PTR_SIZE  read address to instruction memory; equals pc.
- insn_curr  input  INSN_SIZE  instruction word at insn_ptr, combinational from memory.
- fetch_valid  output  1  fetch_insn/fetch_ptr hold a valid instruction.
- fetch_insn  output  INSN_SIZE  registered instruction to decode.
- fetch_ptr  output  INSN_PTR_SIZE  address of fetch_insn.
- fetch_ready  input  1  decode accepts fetch_insn this cycle.
- redirect  input  1  branch taken; restart fetch at redirect_ptr.
- redirect_ptr  input  INSN_PTR_SIZE  branch target.
- halt  input  1  decode saw halt instruction; stop fetching.
- busy  output  1  state==RUN.
- done  output  1  state==DONE.
- fetch_count  output  CNT_SIZE  number of accepted handshakes since last start.

Behaviour:
- Reset values: state=IDLE, pc=0, fetch_valid=0, fetch_insn=0, fetch_ptr=0, fetch_count=0, busy=0, done=0. Reset mid-RUN aborts immediately; no pending output survives.
- States: IDLE, RUN, DONE. busy and done are decoded from the state register (registered, no combinational path from inputs).
- IDLE: start=1 -> pc<=start_ptr, fetch_count<=0, state<=RUN. Otherwise hold.
- RUN, evaluated in priority order each edge:
  1. redirect=1 -> pc<=redirect_ptr, fetch_valid<=0; halt ignored this cycle.
  2. halt=1 -> fetch_valid<=0, state<=DONE; pc holds.
  3. load = ~fetch_valid | fetch_ready. If load: fetch_insn<=insn_curr, fetch_ptr<=pc, fetch_valid<=1, pc<=next(pc).
  4. Else hold all state (back-pressure; fetch_insn stable while fetch_valid & ~fetch_ready).
- start in RUN is ignored.
- next(pc) = 0 if pc==INSN_COUNT-1, else pc+1. Width is INSN_PTR_SIZE, with no overflow beyond the wrap.
- Handshake fires when fetch_valid & fetch_ready at an edge.
  - fetch_count += 1 on each handshake, saturating at all-ones.
  - A handshake in the same cycle as redirect or halt still counts; the slot is then flushed.
- Latency:
  - start sampled at edge E0 -> insn_ptr=start_ptr after E0 -> fetch_valid=1 after E1.
  - Redirect sampled at E0 -> fetch_valid=0 after E0 -> target instruction valid after E1.
  - Steady state with fetch_ready=1: one instruction per cycle.
- DONE: fetch_valid=0, done=1. start=1 -> same as IDLE start, i.e. restart; redirect ignored.
- Memory interaction: insn_curr is used only in RUN. start may coincide with the memory init pulse, because the first capture is one edge later.

Decomposition:
- `INSN_COUNT, `INSN_SIZE and `INSN_PTR_SIZE stay in Inc/Constants.vh.
- Add state encodings to Inc/Constants.vh: `FETCH_IDLE=2'd0, `FETCH_RUN=2'd1, `FETCH_DONE=2'd2.
- Add counter width `FETCH_CNT_SIZE=16 to Inc/Constants.vh.
- Single module; no sub-module. The PC-increment/wrap logic is small enough to stay inline.

Test Plan:
- Reset then start: reset low mid-run, reset high, start_ptr=5 at E0, fetch_ready=1, mem[i]=i+0x100 -> after E1: fetch_valid=1, fetch_insn=0x105, fetch_ptr=5; then 0x106 and 0x107 on consecutive cycles; fetch_count=3 after third accept.
- Back-pressure: fetch_ready=0 for 4 cycles while fetch_valid=1 -> fetch_insn/fetch_ptr/insn_ptr frozen, fetch_count unchanged; fetch_ready=1 -> stream resumes with no skip or duplicate.
- Redirect: redirect=1, redirect_ptr=0x20 while fetch_ptr=9 -> fetch_valid=0 next cycle; fetch_ptr=0x20 the cycle after. Redirect+halt together -> state stays RUN.
- Wrap: start_ptr=INSN_COUNT-2 -> fetch_ptr sequence INSN_COUNT-2, INSN_COUNT-1, 0, 1.
- Halt and restart: halt=1 -> fetch_valid=0, done=1, busy=0; start with start_ptr=3 -> busy=1, fetch_count=0, fetch_ptr=3.
- Saturation: CNT_SIZE=4, 20 accepts -> fetch_count=15.
